// File: rtl/lpif_ustrm_arb_x16.sv
// ---------------------------------------------------------------------------
// lpif_ustrm_arb_x16
// Four-requester, round-robin, credit-gated upstream arbiter that feeds the
// x16 LPIF upstream packer. A grant lasts for up to BURST_MAX beats. Each
// accepted beat is registered onto the ustrm_* bus one cycle later.
// ---------------------------------------------------------------------------
module lpif_ustrm_arb_x16 #(
   parameter int CREDIT_MAX = 16,
   parameter int BURST_MAX  = 4
) (
   input  logic                                clk_wr,
   input  logic                                rst_wr_n,
   input  logic [3:0]                          lnk_state,
   input  logic [3:0]                          req_valid,
   input  logic [2047:0]                       req_data,
   output logic [3:0]                          req_ready,
   input  logic                                credit_return,
   output logic [3:0]                          ustrm_state,
   output logic [1:0]                          ustrm_protid,
   output logic [511:0]                        ustrm_data,
   output logic                                ustrm_dvalid,
   output logic [15:0]                         ustrm_crc,
   output logic                                ustrm_crc_valid,
   output logic                                ustrm_valid,
   output logic [$clog2(CREDIT_MAX+1)-1:0]     credit_cnt,
   output logic                                credit_err
);

   localparam int CW = $clog2(CREDIT_MAX + 1);
   localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam logic [CW-1:0] LP_CREDIT_MAX = CW'(CREDIT_MAX);
   localparam logic [BW-1:0] LP_BEAT_LAST  = BW'(BURST_MAX - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_XFER = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_owner;
   logic [1:0]      r_rr_ptr;
   logic [BW-1:0]   r_beat_cnt;
   logic [CW-1:0]   r_credit_cnt;
   logic            r_credit_err;
   logic [3:0]      r_ustrm_state;
   logic [1:0]      r_ustrm_protid;
   logic [511:0]    r_ustrm_data;
   logic            r_ustrm_dvalid;
   logic            r_ustrm_valid;

   logic            w_lnk_up;
   logic [3:0]      w_ready;
   logic            w_accept;
   logic            w_grant;
   logic            w_release;
   logic [1:0]      w_pick;

   // First valid requester found by searching upward from ptr, modulo 4.
   function automatic logic [1:0] f_rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [1:0] pick;
      logic       found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + k[1:0];
         if (!found && valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end else begin
            pick  = pick;
         end
      end
      return pick;
   endfunction

   assign w_lnk_up = (lnk_state == 4'h1);
   assign w_pick   = f_rr_pick(req_valid, r_rr_ptr);

   // Next-state and handshake decode; a link drop overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 4'b0000;
      w_accept    = 1'b0;
      w_grant     = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_lnk_up) begin
               w_state_nxt = ST_ARB;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ARB: begin
            if (!w_lnk_up) begin
               w_state_nxt = ST_IDLE;
            end else if (|req_valid) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_XFER;
            end else begin
               w_state_nxt = ST_ARB;
            end
         end
         ST_XFER: begin
            w_ready[r_owner] = (r_credit_cnt != {CW{1'b0}});
            w_accept         = req_valid[r_owner] && (r_credit_cnt != {CW{1'b0}});
            if (!w_lnk_up) begin
               w_state_nxt = ST_IDLE;
            end else if ((w_accept && (r_beat_cnt == LP_BEAT_LAST)) || !req_valid[r_owner]) begin
               w_release   = 1'b1;
               w_state_nxt = ST_ARB;
            end else begin
               w_state_nxt = ST_XFER;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Owner, round-robin pointer and burst beat counter. The pointer moves to
   // owner+1 as soon as a grant is made, so an aborted grant still hands the
   // next arbitration to the following requester.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         r_owner    <= 2'd0;
         r_rr_ptr   <= 2'd0;
         r_beat_cnt <= {BW{1'b0}};
      end else if (w_grant) begin
         r_owner    <= w_pick;
         r_rr_ptr   <= w_pick + 2'd1;
         r_beat_cnt <= {BW{1'b0}};
      end else if (w_release) begin
         r_rr_ptr   <= r_owner + 2'd1;
      end else if (w_accept && (r_beat_cnt != LP_BEAT_LAST)) begin
         r_beat_cnt <= r_beat_cnt + {{(BW-1){1'b0}}, 1'b1};
      end
   end

   // Credit counter with reload on link-up and sticky overflow flag.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         r_credit_cnt <= LP_CREDIT_MAX;
         r_credit_err <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_lnk_up) begin
         r_credit_cnt <= LP_CREDIT_MAX;
      end else begin
         case ({w_accept, credit_return})
            2'b10: r_credit_cnt <= r_credit_cnt - {{(CW-1){1'b0}}, 1'b1};
            2'b01: begin
               if (r_credit_cnt == LP_CREDIT_MAX) begin
                  r_credit_err <= 1'b1;
               end else begin
                  r_credit_cnt <= r_credit_cnt + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            default: r_credit_cnt <= r_credit_cnt;
         endcase
      end
   end

   // Upstream output registers: one-cycle datapath latency, hold data when idle.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         r_ustrm_state  <= 4'h0;
         r_ustrm_protid <= 2'd0;
         r_ustrm_data   <= 512'd0;
         r_ustrm_dvalid <= 1'b0;
         r_ustrm_valid  <= 1'b0;
      end else begin
         r_ustrm_state <= lnk_state;
         r_ustrm_valid <= (r_state == ST_ARB) || (r_state == ST_XFER);
         if (w_accept) begin
            r_ustrm_data   <= req_data[{r_owner, 9'd0} +: 512];
            r_ustrm_protid <= r_owner;
            r_ustrm_dvalid <= 1'b1;
         end else begin
            r_ustrm_dvalid <= 1'b0;
         end
      end
   end

   assign req_ready       = w_ready;
   assign ustrm_state     = r_ustrm_state;
   assign ustrm_protid    = r_ustrm_protid;
   assign ustrm_data      = r_ustrm_data;
   assign ustrm_dvalid    = r_ustrm_dvalid;
   assign ustrm_valid     = r_ustrm_valid;
   assign ustrm_crc       = 16'h0000;
   assign ustrm_crc_valid = 1'b0;
   assign credit_cnt      = r_credit_cnt;
   assign credit_err      = r_credit_err;

endmodule

// File: tb/tb_lpif_ustrm_arb_x16.sv
// ---------------------------------------------------------------------------
// Testbench for lpif_ustrm_arb_x16: table vectors, directed corner sequences
// and random traffic, all compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_lpif_ustrm_arb_x16;

   localparam int CREDIT_MAX = 16;
   localparam int BURST_MAX  = 4;

   logic          clk_wr = 1'b0;
   logic          rst_wr_n;
   logic [3:0]    lnk_state;
   logic [3:0]    req_valid;
   logic [2047:0] req_data;
   logic [3:0]    req_ready;
   logic          credit_return;
   logic [3:0]    ustrm_state;
   logic [1:0]    ustrm_protid;
   logic [511:0]  ustrm_data;
   logic          ustrm_dvalid;
   logic [15:0]   ustrm_crc;
   logic          ustrm_crc_valid;
   logic          ustrm_valid;
   logic [4:0]    credit_cnt;
   logic          credit_err;

   always #5 clk_wr = ~clk_wr;

   lpif_ustrm_arb_x16 #(.CREDIT_MAX(CREDIT_MAX), .BURST_MAX(BURST_MAX)) dut (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .lnk_state(lnk_state),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .credit_return(credit_return), .ustrm_state(ustrm_state),
      .ustrm_protid(ustrm_protid), .ustrm_data(ustrm_data),
      .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc),
      .ustrm_crc_valid(ustrm_crc_valid), .ustrm_valid(ustrm_valid),
      .credit_cnt(credit_cnt), .credit_err(credit_err)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: link up flag, ownership, credits, next search start.
   bit           m_linked;
   bit           m_has_owner;
   int           m_owner;
   int           m_beats;
   int           m_next;
   int           m_credits;
   bit           m_err;
   logic [3:0]   e_state;
   logic [1:0]   e_protid;
   logic [511:0] e_data;
   bit           e_dvalid;
   bit           e_valid;

   int           cyc;
   int           beat_pid[$];
   int           beat_cyc[$];
   logic [3:0]   rdy;

   typedef struct {
      logic [3:0] lnk;
      logic [3:0] v;
      bit         cr;
      logic [3:0] x_ready;
      bit         x_dvalid;
      bit         x_valid;
      logic [4:0] x_credit;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_linked = 0; m_has_owner = 0; m_owner = 0; m_beats = 0; m_next = 0;
      m_credits = CREDIT_MAX; m_err = 0;
      e_state = 4'h0; e_protid = 2'd0; e_data = 512'd0; e_dvalid = 0; e_valid = 0;
   endtask

   // One clock: drive at negedge, check ready, advance model, check outputs at next negedge.
   task automatic cycle(input logic [3:0] lnk, input logic [3:0] v, input bit cr, output logic [3:0] obs_ready);
      logic [3:0] m_ready;
      bit acc;
      lnk_state = lnk; req_valid = v; credit_return = cr;
      for (int w = 0; w < 64; w++) req_data[w*32 +: 32] = $urandom;
      #1;
      m_ready = 4'b0000;
      if (m_has_owner && m_credits > 0) m_ready[m_owner] = 1'b1;
      obs_ready = req_ready;
      chk("req_ready", req_ready, m_ready);
      acc = m_has_owner && v[m_owner] && (m_credits > 0);
      e_valid = m_linked;
      e_state = lnk;
      if (acc) begin
         e_dvalid = 1; e_data = req_data[m_owner*512 +: 512]; e_protid = m_owner[1:0];
      end else begin
         e_dvalid = 0;
      end
      if (!m_linked && lnk == 4'h1) m_credits = CREDIT_MAX;
      else if (acc && !cr) m_credits--;
      else if (!acc && cr) begin
         if (m_credits == CREDIT_MAX) m_err = 1;
         else m_credits++;
      end
      if (lnk != 4'h1) begin
         m_linked = 0; m_has_owner = 0;
      end else if (!m_linked) begin
         m_linked = 1;
      end else if (!m_has_owner) begin
         if (v != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
               if (!m_has_owner && v[(m_next + k) % 4]) begin
                  m_owner = (m_next + k) % 4; m_has_owner = 1;
               end
            end
            m_beats = 0;
            m_next = (m_owner + 1) % 4;
         end
      end else begin
         if (acc) m_beats++;
         if ((acc && m_beats == BURST_MAX) || !v[m_owner]) begin
            m_has_owner = 0; m_next = (m_owner + 1) % 4;
         end
      end
      @(posedge clk_wr);
      @(negedge clk_wr);
      cyc++;
      if (ustrm_dvalid) begin beat_pid.push_back(int'(ustrm_protid)); beat_cyc.push_back(cyc); end
      chk("ustrm_valid", ustrm_valid, e_valid);
      chk("ustrm_dvalid", ustrm_dvalid, e_dvalid);
      chk("ustrm_state", ustrm_state, e_state);
      chk("ustrm_protid", ustrm_protid, e_protid);
      chk("ustrm_data", ustrm_data, e_data);
      chk("credit_cnt", credit_cnt, m_credits);
      chk("credit_err", credit_err, m_err);
      chk("ustrm_crc", {ustrm_crc_valid, ustrm_crc}, 17'd0);
   endtask

   task automatic do_reset();
      rst_wr_n = 1'b0; lnk_state = 4'h0; req_valid = 4'h0; credit_return = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_wr);
      chk("rst_ready", req_ready, 4'h0);
      chk("rst_outs", {ustrm_valid, ustrm_dvalid, ustrm_protid, ustrm_state, ustrm_crc_valid, ustrm_crc}, 25'd0);
      chk("rst_data", ustrm_data, 512'd0);
      chk("rst_credit", credit_cnt, 5'd16);
      chk("rst_err", credit_err, 1'b0);
      rst_wr_n = 1'b1;
      beat_pid.delete(); beat_cyc.delete(); cyc = 0;
   endtask

   initial begin
      req_data = '0;
      // Requester 0 alone: 4 beats, bubble, 2 beats, credits 16 -> 10.
      tbl[0]  = '{4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd16};
      tbl[1]  = '{4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd16};
      tbl[2]  = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 5'd15};
      tbl[3]  = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 5'd14};
      tbl[4]  = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 5'd13};
      tbl[5]  = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 5'd12};
      tbl[6]  = '{4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd12};
      tbl[7]  = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 5'd11};
      tbl[8]  = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 5'd10};
      tbl[9]  = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b0, 1'b1, 5'd10};
      tbl[10] = '{4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].lnk, tbl[i].v, tbl[i].cr, rdy);
         chk($sformatf("tbl%0d_ready", i), rdy, tbl[i].x_ready);
         chk($sformatf("tbl%0d_dvalid", i), ustrm_dvalid, tbl[i].x_dvalid);
         chk($sformatf("tbl%0d_valid", i), ustrm_valid, tbl[i].x_valid);
         chk($sformatf("tbl%0d_credit", i), credit_cnt, tbl[i].x_credit);
         chk($sformatf("tbl%0d_protid", i), ustrm_protid, 2'd0);
         if (i == 1) chk("tbl_data_zero", ustrm_data, 512'd0);
      end

      // All four requesters: order 0,1,2,3, one bubble between grants, credit stall.
      do_reset();
      cycle(4'h1, 4'h0, 1'b0, rdy);
      beat_pid.delete(); beat_cyc.delete();
      for (int i = 0; i < 30; i++) cycle(4'h1, 4'hF, 1'b0, rdy);
      chk("rr_beats16", beat_pid.size(), 16);
      for (int b = 0; b < 16 && b < beat_pid.size(); b++) begin
         chk($sformatf("rr_pid%0d", b), beat_pid[b], b / 4);
         if (b > 0) chk($sformatf("rr_gap%0d", b), beat_cyc[b] - beat_cyc[b-1], (b % 4 == 0) ? 2 : 1);
      end
      chk("stall_ready", rdy, 4'h0);
      chk("stall_credit", credit_cnt, 5'd0);
      cycle(4'h1, 4'hF, 1'b1, rdy);
      for (int i = 0; i < 6; i++) cycle(4'h1, 4'hF, 1'b0, rdy);
      chk("one_more_beat", beat_pid.size(), 17);
      if (beat_pid.size() > 0) chk("one_more_pid", beat_pid[beat_pid.size()-1], 0);

      // Coincident accept and credit_return at credit 5.
      do_reset();
      cycle(4'h1, 4'h0, 1'b0, rdy);
      for (int i = 0; i < 40 && credit_cnt != 5'd5; i++) cycle(4'h1, 4'h1, 1'b0, rdy);
      chk("reach_credit5", credit_cnt, 5'd5);
      cycle(4'h1, 4'h1, 1'b1, rdy);
      chk("coinc_accept", rdy, 4'h1);
      chk("coinc_credit5", credit_cnt, 5'd5);

      // Credit overflow at full credit: saturate and sticky error.
      do_reset();
      cycle(4'h1, 4'h0, 1'b0, rdy);
      cycle(4'h1, 4'h0, 1'b1, rdy);
      chk("ovf_credit16", credit_cnt, 5'd16);
      chk("ovf_err", credit_err, 1'b1);
      repeat (2) cycle(4'h1, 4'h0, 1'b0, rdy);
      chk("ovf_err_sticky", credit_err, 1'b1);

      // Link drop on 2nd beat, then resume at owner+1.
      do_reset();
      cycle(4'h1, 4'h0, 1'b0, rdy);
      cycle(4'h1, 4'h2, 1'b0, rdy);
      cycle(4'h1, 4'h2, 1'b0, rdy);
      cycle(4'h0, 4'h2, 1'b0, rdy);
      chk("drop_ready", rdy, 4'h2);
      chk("drop_beat", {ustrm_valid, ustrm_dvalid, ustrm_protid}, 4'b1101);
      cycle(4'h0, 4'h2, 1'b0, rdy);
      chk("idle_ready", rdy, 4'h0);
      chk("idle_valid", {ustrm_valid, ustrm_dvalid}, 2'b00);
      cycle(4'h1, 4'hF, 1'b0, rdy);
      chk("relink_credit", credit_cnt, 5'd16);
      cycle(4'h1, 4'hF, 1'b0, rdy);
      cycle(4'h1, 4'hF, 1'b0, rdy);
      chk("resume_pid", {ustrm_dvalid, ustrm_protid}, 3'b110);

      // Reset asserted mid-burst aborts immediately.
      do_reset();
      cycle(4'h1, 4'h0, 1'b0, rdy);
      cycle(4'h1, 4'h1, 1'b0, rdy);
      cycle(4'h1, 4'h1, 1'b0, rdy);
      rst_wr_n = 1'b0;
      model_reset();
      #1;
      chk("abort_outs", {ustrm_valid, ustrm_dvalid, req_ready, ustrm_protid}, 8'd0);
      chk("abort_data", ustrm_data, 512'd0);
      chk("abort_credit", credit_cnt, 5'd16);
      @(negedge clk_wr);
      rst_wr_n = 1'b1;
      cycle(4'h1, 4'h1, 1'b0, rdy);
      chk("abort_no_beat", ustrm_dvalid, 1'b0);
      cycle(4'h1, 4'h1, 1'b0, rdy);
      cycle(4'h1, 4'h1, 1'b0, rdy);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         logic [3:0] l;
         l = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : 4'h1;
         cycle(l, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
